// File: rtl/bin_bcd_pkg.sv
// Shared types and elaboration helpers for the sequential binary-to-BCD converter.
package bin_bcd_pkg;

  // Converter control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // One packed BCD digit; a result is NDIG of these, units digit in the low nibble.
  localparam int DIGIT_W = 4;
  typedef logic [DIGIT_W-1:0] bcd_digit_t;

  // Smallest digit count able to hold 2^width - 1, i.e. ceil(width * log10(2)).
  // log10(2) is approximated by 30103/100000, which is exact enough for any
  // practical width (the product never lands within rounding error of an integer).
  function automatic int min_digits(input int width);
    return (width * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bin_bcd_seq_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 so that the
// following left shift carries into the next digit exactly when it reaches 10.
module bcd_add3
  import bin_bcd_pkg::*;
(
  input  bcd_digit_t d_i,
  output bcd_digit_t d_o
);

  // Conditional +3 adjust; the sum never exceeds 4 bits for legal digits (max 9+3).
  always_comb begin
    if (d_i >= 4'd5) begin
      d_o = d_i + 4'd3;
    end else begin
      d_o = d_i;
    end
  end

endmodule

// File: rtl/bin_bcd_seq.sv
// Sequential binary-to-BCD converter using iterative double-dabble: one adjust
// and one shift per clock, valid/ready on both sides, optional signed input
// producing a sign flag plus the BCD magnitude.
module bin_bcd_seq
  import bin_bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int NDIG   = 3,
  parameter int SIGNED = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BIN_W-1:0]    bin_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*NDIG-1:0]   bcd_out,
  output logic                sign_out
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = DIGIT_W * NDIG;

  // Elaboration-time parameter sanity.
  if (BIN_W < 2) begin : g_bad_width
    $error("bin_bcd_seq: BIN_W must be at least 2");
  end
  if (NDIG < min_digits(BIN_W)) begin : g_bad_ndig
    $error("bin_bcd_seq: NDIG too small to hold 2^BIN_W - 1");
  end

  state_e             state_q,     state_d;
  logic [BIN_W-1:0]   shreg_q,     shreg_d;
  logic [BCD_W-1:0]   acc_q,       acc_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic               neg_q,       neg_d;
  logic [BCD_W-1:0]   bcd_q,       bcd_d;
  logic               sign_q,      sign_d;
  logic               in_ready_q,  in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic [BCD_W-1:0]       adj_s;
  logic [BIN_W-1:0]       mag_s;
  logic                   neg_s;
  logic [BCD_W+BIN_W-1:0] shifted_s;
  logic                   unused_s;

  // Per-digit add-3 correction applied to the current accumulator.
  for (genvar g = 0; g < NDIG; g++) begin : g_add3
    bcd_add3 u_add3 (
      .d_i (acc_q[DIGIT_W*g +: DIGIT_W]),
      .d_o (adj_s[DIGIT_W*g +: DIGIT_W])
    );
  end

  // The top accumulator bit is shifted out; it is always zero because NDIG
  // is large enough for the full input range.
  assign unused_s = adj_s[BCD_W-1];

  // Input magnitude and sign; the negate is done in BIN_W bits so the most
  // negative value maps onto its unsigned magnitude 2^(BIN_W-1).
  always_comb begin
    if ((SIGNED != 0) && bin_in[BIN_W-1]) begin
      mag_s = ~bin_in + {{(BIN_W-1){1'b0}}, 1'b1};
      neg_s = 1'b1;
    end else begin
      mag_s = bin_in;
      neg_s = 1'b0;
    end
  end

  // Adjusted accumulator and shift register shifted left together by one bit.
  always_comb begin
    shifted_s = {adj_s[BCD_W-2:0], shreg_q, 1'b0};
  end

  // Next-state, datapath and output-flag logic.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    bcd_d   = bcd_q;
    sign_d  = sign_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shreg_d = mag_s;
          neg_d   = neg_s;
          acc_d   = '0;
          cnt_d   = CNT_W'(BIN_W);
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        acc_d   = shifted_s[BCD_W+BIN_W-1:BIN_W];
        shreg_d = shifted_s[BIN_W-1:0];
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          // Last shift: publish the result as the state enters DONE.
          bcd_d   = shifted_s[BCD_W+BIN_W-1:BIN_W];
          sign_d  = neg_q;
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      bcd_q       <= '0;
      sign_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      neg_q       <= neg_d;
      bcd_q       <= bcd_d;
      sign_q      <= sign_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign bcd_out   = bcd_q;
  assign sign_out  = sign_q;

endmodule

// File: tb/tb_bin_bcd_seq.sv
// Self-checking bench: three converters (8-bit unsigned, 8-bit signed,
// 16-bit unsigned) against a behavioural model using decimal arithmetic.
module tb_bin_bcd_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst_v  = 3'b111;
  logic [2:0]  inv_v  = 3'b000;
  logic [2:0]  ordy_v = 3'b111;
  wire  [2:0]  ov_v;
  wire  [2:0]  ir_v;
  wire  [2:0]  sg_v;
  logic [7:0]  b0 = 8'd0;
  logic [7:0]  b1 = 8'd0;
  logic [15:0] b2 = 16'd0;
  wire  [11:0] bcd0;
  wire  [11:0] bcd1;
  wire  [19:0] bcd2;

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_en = 1'b0;

  bin_bcd_seq #(.BIN_W(8), .NDIG(3), .SIGNED(0)) u_dut0 (
    .clk(clk), .rst(rst_v[0]), .in_valid(inv_v[0]), .in_ready(ir_v[0]),
    .bin_in(b0), .out_valid(ov_v[0]), .out_ready(ordy_v[0]),
    .bcd_out(bcd0), .sign_out(sg_v[0]));

  bin_bcd_seq #(.BIN_W(8), .NDIG(3), .SIGNED(1)) u_dut1 (
    .clk(clk), .rst(rst_v[1]), .in_valid(inv_v[1]), .in_ready(ir_v[1]),
    .bin_in(b1), .out_valid(ov_v[1]), .out_ready(ordy_v[1]),
    .bcd_out(bcd1), .sign_out(sg_v[1]));

  bin_bcd_seq #(.BIN_W(16), .NDIG(5), .SIGNED(0)) u_dut2 (
    .clk(clk), .rst(rst_v[2]), .in_valid(inv_v[2]), .in_ready(ir_v[2]),
    .bin_in(b2), .out_valid(ov_v[2]), .out_ready(ordy_v[2]),
    .bcd_out(bcd2), .sign_out(sg_v[2]));

  function automatic int wd(input int d);
    return (d == 2) ? 16 : 8;
  endfunction

  function automatic bit sgd(input int d);
    return (d == 1);
  endfunction

  function automatic int binv(input int d);
    case (d)
      0:       return int'(b0);
      1:       return int'(b1);
      default: return int'(b2);
    endcase
  endfunction

  function automatic logic [19:0] getbcd(input int d);
    case (d)
      0:       return {8'd0, bcd0};
      1:       return {8'd0, bcd1};
      default: return bcd2;
    endcase
  endfunction

  // Decimal digits by repeated division, units digit in the low nibble.
  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_bin(input int d, input int v);
    case (d)
      0:       b0 = 8'(v);
      1:       b1 = 8'(v);
      default: b2 = 16'(v);
    endcase
  endtask

  // Model: 0 = waiting for input, 1 = converting, 2 = presenting a result.
  int          m_st   [3];
  int          m_rem  [3];
  logic [19:0] m_pend [3];
  logic        m_psg  [3];
  logic [19:0] m_bcd  [3];
  logic        m_sign [3];
  int          m_done [3];
  int          dut_hs [3];
  int          mv;
  logic        mneg;

  initial begin
    for (int d = 0; d < 3; d++) begin
      m_st[d] = 0; m_rem[d] = 0; m_pend[d] = '0; m_psg[d] = 1'b0;
      m_bcd[d] = '0; m_sign[d] = 1'b0; m_done[d] = 0; dut_hs[d] = 0;
    end
  end

  // Reference model plus DUT handshake counting, evaluated on input values seen at the edge.
  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (ov_v[d] && ordy_v[d] && !rst_v[d]) dut_hs[d]++;
      if (rst_v[d]) begin
        m_st[d] = 0; m_bcd[d] = '0; m_sign[d] = 1'b0;
      end else if (m_st[d] == 0) begin
        if (inv_v[d]) begin
          mv = binv(d);
          mneg = 1'b0;
          if (sgd(d) && mv >= (1 << (wd(d) - 1))) begin
            mv = (1 << wd(d)) - mv;
            mneg = 1'b1;
          end
          m_pend[d] = to_bcd(mv);
          m_psg[d]  = mneg;
          m_rem[d]  = wd(d);
          m_st[d]   = 1;
        end
      end else if (m_st[d] == 1) begin
        m_rem[d]--;
        if (m_rem[d] == 0) begin
          m_st[d] = 2; m_bcd[d] = m_pend[d]; m_sign[d] = m_psg[d];
        end
      end else if (ordy_v[d]) begin
        m_st[d] = 0;
        m_done[d]++;
      end
    end
  end

  // Per-cycle comparison of every converter's outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("cycle dut%0d {ov,ir,sign,bcd}", d),
            {9'd0, ov_v[d], ir_v[d], sg_v[d], getbcd(d)},
            {9'd0, (m_st[d] == 2), (m_st[d] == 0), m_sign[d], m_bcd[d]});
      end
    end
  end

  // One conversion on DUT d (which must be idle); checks latency and result.
  task automatic convert(input int d, input int val, input logic [19:0] eb,
                         input logic es, input string nm);
    int lat;
    set_bin(d, val);
    inv_v[d] = 1'b1;
    @(posedge clk); #1;
    inv_v[d] = 1'b0;
    set_bin(d, val ^ 32'h5A5A);
    lat = 0;
    while (ov_v[d] !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, " latency"}, 32'(lat), 32'(wd(d)));
    chk({nm, " bcd"}, {12'd0, getbcd(d)}, {12'd0, eb});
    chk({nm, " sign"}, {31'd0, sg_v[d]}, {31'd0, es});
    if (ordy_v[d]) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Model pins: hand-computed decimal encodings.
    chk("model 255", {12'd0, to_bcd(255)}, 32'h00255);
    chk("model 65535", {12'd0, to_bcd(65535)}, 32'h65535);
    chk("model 1000", {12'd0, to_bcd(1000)}, 32'h01000);

    repeat (2) @(posedge clk);
    #1;
    rst_v = 3'b000;
    chk_en = 1'b1;
    chk("reset in_ready", {31'd0, ir_v[0]}, 32'd1);
    chk("reset out_valid", {31'd0, ov_v[0]}, 32'd0);
    chk("reset bcd", {20'd0, bcd0}, 32'd0);
    chk("reset sign", {31'd0, sg_v[1]}, 32'd0);

    // Unsigned 8-bit.
    convert(0, 255, 20'h255, 1'b0, "u8 255");
    convert(0, 0,   20'h000, 1'b0, "u8 0");
    convert(0, 99,  20'h099, 1'b0, "u8 99");
    // Signed 8-bit, including the most negative value.
    convert(1, 8'h80, 20'h128, 1'b1, "s8 80");
    convert(1, 8'hFF, 20'h001, 1'b1, "s8 FF");
    convert(1, 8'h7F, 20'h127, 1'b0, "s8 7F");
    convert(1, 8'h9C, 20'h100, 1'b1, "s8 9C");
    // 16-bit, five digits.
    convert(2, 65535, 20'h65535, 1'b0, "u16 65535");
    convert(2, 10000, 20'h10000, 1'b0, "u16 10000");

    // Backpressure: result holds while out_ready is low; new inputs ignored.
    ordy_v[0] = 1'b0;
    convert(0, 100, 20'h100, 1'b0, "bp 100");
    for (int i = 0; i < 20; i++) begin
      inv_v[0] = i[0];
      b0 = 8'($urandom);
      @(posedge clk); #1;
    end
    inv_v[0] = 1'b0;
    chk("bp hold out_valid", {31'd0, ov_v[0]}, 32'd1);
    chk("bp hold in_ready", {31'd0, ir_v[0]}, 32'd0);
    chk("bp hold bcd", {20'd0, bcd0}, 32'h100);
    ordy_v[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp release in_ready", {31'd0, ir_v[0]}, 32'd1);
    chk("bp release out_valid", {31'd0, ov_v[0]}, 32'd0);

    // Reset during the fourth shift cycle of 200 discards that word.
    b0 = 8'd200;
    inv_v[0] = 1'b1;
    @(posedge clk); #1;
    inv_v[0] = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_v[0] = 1'b1;
    @(posedge clk); #1;
    rst_v[0] = 1'b0;
    chk("abort out_valid", {31'd0, ov_v[0]}, 32'd0);
    chk("abort in_ready", {31'd0, ir_v[0]}, 32'd1);
    chk("abort bcd", {20'd0, bcd0}, 32'd0);
    convert(0, 37, 20'h037, 1'b0, "after abort 37");

    // Back-to-back streaming on the 16-bit converter with a changing input word.
    inv_v[2] = 1'b1;
    for (int i = 0; i < 18020; i++) begin
      @(posedge clk); #1;
      b2 = 16'($urandom);
    end
    inv_v[2] = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("stream handshakes vs model", 32'(dut_hs[2]), 32'(m_done[2]));
    chk("stream at least 1000 results", {31'd0, (dut_hs[2] >= 1000)}, 32'd1);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bin_bcd_seq.md
# bin_bcd_seq

Sequential, parametrised binary-to-BCD converter using iterative double-dabble (shift-add-3). It performs one digit-adjust and one shift per clock. Input and output are valid/ready handshakes, and an optional signed mode produces a sign flag plus the BCD magnitude. It sits between datapath counters/accumulators and display or UART formatting logic, replacing purely combinational conversion where width makes that too deep.

## Interface
Parameters:
- BIN_W, 8, binary input width in bits (≥ 2).
- NDIG, 3, number of BCD digits output; must satisfy 10^NDIG > 2^BIN_W − 1, else elaboration error.
- SIGNED, 0, 1 = input is two's complement; converts magnitude and reports sign.

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input word present.
- in_ready  out  1  converter can accept a word.
- bin_in  in  BIN_W  binary value.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- bcd_out  out  4*NDIG  packed BCD, digit 0 (units) in bits [3:0].
- sign_out  out  1  1 = negative input (SIGNED=1 only; tied 0 otherwise).

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid, the value is accepted and loaded into the shift register. If SIGNED=1 and MSB=1, the register gets the magnitude (two's-complement negate, computed in BIN_W bits as unsigned; −2^(BIN_W−1) yields 2^(BIN_W−1)) and the sign is latched. The BCD accumulator clears, bit counter = BIN_W, and the state goes to SHIFT.
- SHIFT: each cycle, every digit ≥ 5 gets +3 (4-bit add, no carry out). Then {accumulator, shift register} shifts left by 1 and the counter decrements. When the counter reaches 0 after this shift, the state goes to DONE.
- DONE: out_valid=1; bcd_out and sign_out are stable. On out_ready, go to IDLE.
- Adjust precedes shift in the same cycle. The adjust is never applied after the final shift.
- in_ready is 0 in SHIFT and DONE. in_valid is ignored there; no queuing.
- bcd_out and sign_out are registered and change only on entry to DONE.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, bcd_out=0, sign_out=0, counter=0.
- Accept at edge E0. Shifts occur at edges E1..E_BIN_W. out_valid goes high after E_BIN_W, so latency is BIN_W cycles from accept to out_valid.
- With out_ready held high, out_valid lasts 1 cycle and in_ready returns the next cycle. Minimum period is BIN_W+2 cycles per conversion.
- Backpressure: out_valid and data hold indefinitely while out_ready=0.
- Reset mid-SHIFT or mid-DONE aborts: the result is discarded, all reset values apply the next cycle, and no out_valid is produced for the aborted word.
- rst has priority over in_valid in the same cycle.
- The input word is sampled only at accept; bin_in changes afterwards have no effect.

## Structure
- Package bin_bcd_pkg holds:
  - state enum (IDLE, SHIFT, DONE);
  - constant function min_digits(width) = ceil(width·log10 2), used for the NDIG assertion;
  - the packed-digit type helper.
- Sub-module bcd_add3: combinational, 4-bit in/out, returns d+3 if d ≥ 5 else d.
  - Instantiated NDIG times with generate; the parent holds all registers.
- Counter width is $clog2(BIN_W+1).

## Test plan
- BIN_W=8, NDIG=3, unsigned: 255 → bcd_out=12'h255 with out_valid exactly 8 cycles after accept; 0 → 12'h000; 99 → 12'h099.
- SIGNED=1, BIN_W=8, NDIG=3:
  - 8'h80 → sign_out=1, bcd_out=12'h128;
  - 8'hFF → sign_out=1, 12'h001;
  - 8'h7F → sign_out=0, 12'h127.
- Backpressure: hold out_ready=0 for 20 cycles → out_valid stays 1, data stable, in_ready=0, and in_valid pulses are ignored. Releasing out_ready then gives in_ready=1 the next cycle.
- Reset asserted on the 4th SHIFT cycle of input 200 → next cycle IDLE, out_valid=0, bcd_out=0. A following input of 37 yields 12'h037.
- BIN_W=16, NDIG=5: 65535 → 20'h65535 after 16 cycles; 10000 → 20'h10000. Back-to-back in_valid streaming of 1000 random values matches the reference model, one result per 18 cycles.
